// File: rtl/operand_forward_unit.sv
// Operand forwarding from a short history of completed instructions.
// Pending loads are filled in place; readers of an unfilled load stall.
module operand_forward_unit #(
  parameter int XLEN   = 32,
  parameter int NPORTS = 2,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    ex_valid,
  input  logic                    ex_we,
  input  logic                    ex_is_load,
  input  logic [4:0]              ex_rd,
  input  logic [XLEN-1:0]         ex_result,
  input  logic                    ld_rsp_valid,
  input  logic [XLEN-1:0]         ld_rsp_data,
  input  logic [NPORTS*5-1:0]     rs_addr,
  input  logic [NPORTS*XLEN-1:0]  rf_rdata,
  output logic [NPORTS*XLEN-1:0]  fwd_data,
  output logic [NPORTS-1:0]       fwd_hit,
  output logic                    stall,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic                    ld_err
);

  logic [DEPTH-1:0] h_valid;
  logic [DEPTH-1:0] h_we;
  logic [DEPTH-1:0] h_ready;
  logic [4:0]       h_rd   [DEPTH];
  logic [XLEN-1:0]  h_data [DEPTH];

  logic [DEPTH-1:0] pend_vec;
  logic [DEPTH-1:0] f_ready;
  logic [XLEN-1:0]  f_data [DEPTH];
  logic [NPORTS-1:0] p_rdy;
  logic             pend_any;
  logic             port_wait;
  logic             load_wait;

  // History view with this cycle's load response already merged in
  always_comb begin
    pend_vec = h_valid & ~h_ready;
    pend_any = |pend_vec;
    f_ready  = h_ready;
    for (int i = 0; i < DEPTH; i++) begin
      f_data[i] = h_data[i];
      if (ld_rsp_valid && pend_vec[i]) begin
        f_ready[i] = 1'b1;
        f_data[i]  = ld_rsp_data;
      end
    end
  end

  // Oldest-to-youngest scan so the youngest match wins
  always_comb begin
    fwd_data  = rf_rdata;
    fwd_hit   = '0;
    p_rdy     = '1;
    port_wait = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (rs_addr[p*5 +: 5] != 5'd0 && h_valid[i] && h_we[i] &&
            h_rd[i] == rs_addr[p*5 +: 5]) begin
          fwd_hit[p]             = 1'b1;
          p_rdy[p]               = f_ready[i];
          fwd_data[p*XLEN +: XLEN] = f_data[i];
        end
      end
      port_wait = port_wait | (fwd_hit[p] & ~p_rdy[p]);
    end
  end

  always_comb begin
    load_wait = ex_valid & ex_is_load & pend_any & ~ld_rsp_valid;
    stall     = ~rst & ~flush & (port_wait | load_wait);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_valid   <= '0;
      stall_cnt <= '0;
      ld_err    <= 1'b0;
    end else begin
      if (ld_rsp_valid && !pend_any)
        ld_err <= 1'b1;
      if (stall && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
      if (flush) begin
        h_valid <= '0;
      end else if (!stall) begin
        h_valid[0] <= ex_valid;
        for (int i = 1; i < DEPTH; i++)
          h_valid[i] <= h_valid[i-1];
      end
    end
  end

  // Payload needs no reset: it is only observed through h_valid
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (stall) begin
        h_ready <= f_ready;
        for (int i = 0; i < DEPTH; i++)
          h_data[i] <= f_data[i];
      end else begin
        h_we[0]    <= ex_we;
        h_rd[0]    <= ex_rd;
        h_ready[0] <= ~ex_is_load;
        h_data[0]  <= ex_result;
        for (int i = 1; i < DEPTH; i++) begin
          h_we[i]    <= h_we[i-1];
          h_rd[i]    <= h_rd[i-1];
          h_ready[i] <= f_ready[i-1];
          h_data[i]  <= f_data[i-1];
        end
      end
    end
  end

endmodule
